// File: rtl/sram_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : sram_mem_ctrl
// Purpose  : MEM-stage data access as two 16-bit asynchronous SRAM accesses
//            with programmable wait states. Optional: SRAM_MEM_CTRL_POSTED_WRITE_EN
// Revision : 1.0 - initial release
// ============================================================================
module sram_mem_ctrl #(
  parameter int ADDR_BASE   = 1024,
  parameter int WAIT_CYCLES = 5,
  parameter int SRAM_AW     = 18
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_en,
  input  logic               rd_en,
  input  logic [31:0]        address,
  input  logic [31:0]        wdata,
  output logic [31:0]        rdata,
  output logic               ready,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [15:0]        sram_dq_o,
  output logic               sram_dq_oe,
  input  logic [15:0]        sram_dq_i,
  output logic               sram_we_n,
  output logic               sram_oe_n
);

  localparam int            CW       = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CW-1:0] C_LAST   = CW'(WAIT_CYCLES - 1);
  localparam bit            C_SINGLE = (WAIT_CYCLES == 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LO   = 2'd1,
    S_HI   = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t               r_state;
  state_t               w_next;
  logic [CW-1:0]        r_cnt;
  logic                 r_is_wr;
  logic [SRAM_AW-2:0]   r_word;
  logic [31:0]          r_wdata;
  logic [31:0]          r_rdata;

  logic                 w_req;
  logic                 w_last;
  logic                 w_hi;
  logic [31:0]          w_off;
  logic [SRAM_AW-2:0]   w_word;
  logic                 w_unused;

  assign w_req    = rd_en | wr_en;
  assign w_last   = (r_cnt == C_LAST);
  assign w_hi     = (r_state == S_HI);
  assign w_off    = address - 32'(ADDR_BASE);
  assign w_word   = w_off[SRAM_AW:2];
  assign w_unused = ^{w_off[31:SRAM_AW+1], w_off[1:0]};
  assign rdata    = r_rdata;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_is_wr <= 1'b0;
      r_word  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
          if (w_req) begin
            r_word  <= w_word;
            r_wdata <= wdata;
            r_is_wr <= wr_en;
          end
        end
        S_LO, S_HI: begin
          r_cnt <= w_last ? '0 : r_cnt + CW'(1);
          // Read data is captured at the end of the full wait window.
          if (!r_is_wr && w_last) begin
            if (w_hi) r_rdata[31:16] <= sram_dq_i;
            else      r_rdata[15:0]  <= sram_dq_i;
          end
        end
        default: r_cnt <= '0;
      endcase
    end
  end

  always_comb begin
    w_next     = r_state;
    ready      = 1'b0;
    sram_addr  = {r_word, 1'b0};
    sram_dq_o  = '0;
    sram_dq_oe = 1'b0;
    sram_we_n  = 1'b1;
    sram_oe_n  = 1'b1;
    case (r_state)
      S_IDLE: begin
        ready = ~w_req;
`ifdef SRAM_MEM_CTRL_POSTED_WRITE_EN
        if (wr_en) ready = 1'b1;
`endif
        if (w_req) w_next = S_LO;
      end
      S_LO, S_HI: begin
        sram_addr = {r_word, w_hi};
        if (r_is_wr) begin
          sram_dq_o  = w_hi ? r_wdata[31:16] : r_wdata[15:0];
          sram_dq_oe = 1'b1;
          // Strobe released one cycle early so data is held past we_n rise.
          sram_we_n  = w_last & ~C_SINGLE;
`ifdef SRAM_MEM_CTRL_POSTED_WRITE_EN
          ready      = ~w_req;
`endif
        end else begin
          sram_oe_n = 1'b0;
        end
        if (w_last) begin
          if (!w_hi) w_next = S_HI;
`ifdef SRAM_MEM_CTRL_POSTED_WRITE_EN
          else if (r_is_wr) w_next = S_IDLE;
`endif
          else w_next = S_DONE;
        end
      end
      S_DONE: begin
        ready  = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
    if (!rst) ready = 1'b0;
  end

endmodule
`default_nettype wire

// File: tb/tb_sram_mem_ctrl.sv
`default_nettype none
// Directed bench for sram_mem_ctrl with a model SRAM and write/read scoreboards.
module tb_sram_mem_ctrl;
  localparam int W    = 5;
  localparam int BASE = 1024;
  localparam int AW   = 18;
`ifdef SRAM_MEM_CTRL_POSTED_WRITE_EN
  localparam bit POSTED = 1'b1;
`else
  localparam bit POSTED = 1'b0;
`endif
  localparam int RD_LAT = 2*W + 1;
  localparam int WR_LAT = POSTED ? 0 : 2*W + 1;

  logic          clk;
  logic          rst;
  logic          wr_en;
  logic          rd_en;
  logic [31:0]   address;
  logic [31:0]   wdata;
  logic [31:0]   rdata;
  logic          ready;
  logic [AW-1:0] sram_addr;
  logic [15:0]   sram_dq_o;
  logic          sram_dq_oe;
  logic [15:0]   sram_dq_i;
  logic          sram_we_n;
  logic          sram_oe_n;

  sram_mem_ctrl #(.ADDR_BASE(BASE), .WAIT_CYCLES(W), .SRAM_AW(AW)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en),
    .address(address), .wdata(wdata), .rdata(rdata), .ready(ready),
    .sram_addr(sram_addr), .sram_dq_o(sram_dq_o), .sram_dq_oe(sram_dq_oe),
    .sram_dq_i(sram_dq_i), .sram_we_n(sram_we_n), .sram_oe_n(sram_oe_n)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  logic [15:0] mem [0:1023];
  assign sram_dq_i = sram_oe_n ? 16'h0000 : mem[sram_addr[9:0]];
  always @(posedge clk)
    if (!sram_we_n && sram_dq_oe) mem[sram_addr[9:0]] <= sram_dq_o;

  int          checks   = 0;
  int          failures = 0;
  logic [31:0] rd_q  [$];
  logic [33:0] exp_wq[$];
  logic [33:0] obs_wq[$];
  int          we_low = 0;
  int          hold   = 0;
  logic        prev_we = 1'b1;

  always @(negedge clk) begin
    if (!sram_we_n) begin
      we_low++;
      if (prev_we) obs_wq.push_back({sram_addr, sram_dq_o});
    end
    if (sram_we_n && sram_dq_oe) hold++;
    prev_we = sram_we_n;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic exp_write(input logic [31:0] addr, input logic [31:0] data);
    int wd;
    wd = int'((addr - BASE) >> 2) & ((1 << (AW-1)) - 1);
    exp_wq.push_back({AW'(wd*2),     data[15:0]});
    exp_wq.push_back({AW'(wd*2 + 1), data[31:16]});
  endtask

  task automatic verify_writes(input int n_wr);
    check("wr_events", obs_wq.size(), exp_wq.size());
    while (obs_wq.size() > 0 && exp_wq.size() > 0)
      check("wr_addr_data", obs_wq.pop_front(), exp_wq.pop_front());
    check("we_low_cycles", we_low, n_wr * 2 * (W-1));
    check("we_hold_cycles", hold, n_wr * 2);
    obs_wq.delete();
    exp_wq.delete();
    we_low = 0;
    hold   = 0;
  endtask

  // Caller is at posedge+1; returns at posedge+1 after the ready cycle.
  task automatic access(input bit wr, input bit rd, input logic [31:0] addr,
                        input logic [31:0] data, input int exp_lat, input bit drain);
    int          lat;
    bit          done;
    logic [31:0] e;
    wr_en = wr; rd_en = rd; address = addr; wdata = data;
    lat = 0; done = 0;
    while (!done && lat < 100) begin
      @(negedge clk);
      if (ready) done = 1;
      else       lat++;
    end
    check("latency", lat, exp_lat);
    if (rd && !wr) begin
      e = rd_q.pop_front();
      check("rdata", rdata, e);
    end
    @(posedge clk); #1;
    wr_en = 0; rd_en = 0;
    if (POSTED && wr && drain) begin
      repeat (2*W) @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst = 0; wr_en = 0; rd_en = 0; address = 0; wdata = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ready", ready, 0);
    check("rst_we_n", sram_we_n, 1);
    check("rst_oe_n", sram_oe_n, 1);
    check("rst_dq_oe", sram_dq_oe, 0);
    check("rst_rdata", rdata, 0);
    check("rst_addr", sram_addr, 0);
    check("rst_dq_o", sram_dq_o, 0);
    @(posedge clk); #1 rst = 1;
    @(negedge clk);
    check("idle_ready", ready, 1);

    // Reset asserted in the middle of the low-half write
    @(posedge clk); #1;
    wr_en = 1; address = BASE; wdata = 32'h1111_2222;
    repeat (3) @(negedge clk);
    check("mid_we_n_low", sram_we_n, 0);
    #2 rst = 0;
    #1;
    check("mid_rst_we_n", sram_we_n, 1);
    check("mid_rst_dq_oe", sram_dq_oe, 0);
    check("mid_rst_ready", ready, 0);
    check("mid_rst_addr", sram_addr, 0);
    wr_en = 0;
    @(posedge clk); #1 rst = 1;
    @(negedge clk);
    check("post_rst_ready", ready, 1);
    check("post_rst_we_n", sram_we_n, 1);
    obs_wq.delete(); we_low = 0; hold = 0;
    @(posedge clk); #1;

    // Write then read back at the base address
    exp_write(BASE, 32'hDEAD_BEEF);
    access(1, 0, BASE, 32'hDEAD_BEEF, WR_LAT, 1);
    verify_writes(1);
    rd_q.push_back(32'hDEAD_BEEF);
    access(0, 1, BASE, 32'h0, RD_LAT, 1);
    verify_writes(0);

    // Low address bits ignored: halves at 14 and 15
    exp_write(BASE + 4*7 + 3, 32'h1234_5678);
    access(1, 0, BASE + 4*7 + 3, 32'h1234_5678, WR_LAT, 1);
    verify_writes(1);
    rd_q.push_back(32'h1234_5678);
    access(0, 1, BASE + 4*7, 32'h0, RD_LAT, 1);

    // Back-to-back read then write; both enables set performs a write
    rd_q.push_back(32'hDEAD_BEEF);
    access(0, 1, BASE, 32'h0, RD_LAT, 1);
    exp_write(BASE + 8, 32'hCAFE_F00D);
    access(1, 1, BASE + 8, 32'hCAFE_F00D, WR_LAT, 1);
    check("rdata_kept", rdata, 32'hDEAD_BEEF);
    verify_writes(1);

    // Write immediately followed by a read of the same word
    exp_write(BASE + 40, 32'h0BAD_CAFE);
    access(1, 0, BASE + 40, 32'h0BAD_CAFE, WR_LAT, 0);
    rd_q.push_back(32'h0BAD_CAFE);
    access(0, 1, BASE + 40, 32'h0, POSTED ? 4*W + 1 : RD_LAT, 1);
    verify_writes(1);
    check("rd_q_empty", rd_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
